shift_arbiter: RTL and testbench

- Sequencer and arbiter that shares one 32-bit mux-based logical right-shift datapath between two requesters, for example the ALU and the address/immediate unit.
- Builds three operations from logical right shift alone:
  - SRL: one datapath pass.
  - SLL: bit-reverse the operand, shift, bit-reverse the result.
  - SRA: one pass on all-ones to form a fill mask, then one pass on the operand.
- Requests use valid/ready; results return on one shared response channel tagged with the requester id.

---
 rtl/shift_arbiter.sv | 138 +++++++++++++
 tb/tb_shift_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Two-requester arbiter sharing one logical right-shift datapath; SLL and SRA
// are built from right shifts via bit reversal and an all-ones fill mask.
module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_shamt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, MASK, SHIFT, RESP} state_t;

    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;

    state_t           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             id_q, id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [WIDTH-1:0] data_rev, shift_in1, shift_out, shift_out_rev;
    logic             any_valid, grant_id, in_idle;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign data_rev[gi]      = data_q[WIDTH-1-gi];
        assign shift_out_rev[gi] = shift_out[WIDTH-1-gi];
    end

    // The single shared shifter: its operand depends on which pass is running.
    assign shift_in1 = (state_q == MASK)  ? {WIDTH{1'b1}} :
                       (op_q == OP_SLL)   ? data_rev      : data_q;
    assign shift_out = shift_in1 >> shamt_q;

    assign in_idle   = (state_q == IDLE);
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

    // Gated by rst so the readys read zero while reset is held.
    assign req0_ready = in_idle && !rst && any_valid && !grant_id;
    assign req1_ready = in_idle && !rst && any_valid &&  grant_id;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = !in_idle;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        data_d      = data_q;
        shamt_d     = shamt_q;
        mask_d      = mask_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    id_d     = grant_id;
                    rr_ptr_d = ~grant_id;
                    op_d     = grant_id ? req1_op    : req0_op;
                    data_d   = grant_id ? req1_data  : req0_data;
                    shamt_d  = grant_id ? req1_shamt : req0_shamt;
                    state_d  = (op_d == OP_SRA) ? MASK : SHIFT;
                end
            end
            MASK: begin
                mask_d  = ~shift_out;
                state_d = SHIFT;
            end
            SHIFT: begin
                case (op_q)
                    OP_SLL:  rsp_data_d = shift_out_rev;
                    OP_SRA:  rsp_data_d = data_q[WIDTH-1] ? (shift_out | mask_q) : shift_out;
                    default: rsp_data_d = shift_out;
                endcase
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            id_q        <= 1'b0;
            op_q        <= 2'b00;
            data_q      <= '0;
            shamt_q     <= '0;
            mask_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            data_q      <= data_d;
            shamt_q     <= shamt_d;
            mask_q      <= mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a transaction-level reference model checked every
// cycle, directed literal cases, and randomized two-requester traffic.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;

    int errors = 0;
    int checks = 0;

    // Model state: one command in flight, k cycles after its accept cycle.
    logic        m_busy, m_id, m_rr;
    int          m_k, m_lat;
    logic [31:0] m_data;
    logic        acc0, acc1;

    always #5 clk = ~clk;

    shift_arbiter #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] s);
        case (op)
            2'b01:   return 32'($signed(d) >>> s);
            2'b10:   return d << s;
            default: return d >> s;
        endcase
    endfunction

    initial begin : compare
        logic any, g;
        forever begin
            @(negedge clk);
            acc0 = 1'b0;
            acc1 = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
                m_rr   = 1'b0;
            end else if (!m_busy) begin
                any = req0_valid | req1_valid;
                g   = (req0_valid && req1_valid) ? m_rr : req1_valid;
                chk("idle_req0_ready", req0_ready, any && !g);
                chk("idle_req1_ready", req1_ready, any && g);
                chk("idle_busy", busy, 1'b0);
                chk("idle_rsp_valid", rsp_valid, 1'b0);
                if (any) begin
                    m_busy = 1'b1;
                    m_k    = 0;
                    m_id   = g;
                    m_rr   = ~g;
                    m_data = g ? ref_shift(req1_op, req1_data, req1_shamt)
                               : ref_shift(req0_op, req0_data, req0_shamt);
                    m_lat  = ((g ? req1_op : req0_op) == 2'b01) ? 3 : 2;
                    acc0   = !g;
                    acc1   = g;
                end
            end else begin
                m_k++;
                chk("busy_req0_ready", req0_ready, 1'b0);
                chk("busy_req1_ready", req1_ready, 1'b0);
                chk("busy_flag", busy, 1'b1);
                chk("rsp_valid_timing", rsp_valid, m_k >= m_lat);
                if (m_k >= m_lat) begin
                    chk("rsp_id", rsp_id, m_id);
                    chk("rsp_data", rsp_data, m_data);
                    if (rsp_ready) m_busy = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic id, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] s);
        if (!id) begin
            req0_valid = 1'b1; req0_op = op; req0_data = d; req0_shamt = s;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_data = d; req1_shamt = s;
        end
    endtask

    task automatic wait_acc(input logic id, output bit got);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk); #1;
            got = id ? acc1 : acc0;
        end
    endtask

    task automatic wait_rsp(output int n, output bit got);
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk); #1;
            n++;
            got = rsp_valid;
        end
    endtask

    task automatic run_one(input logic id, input logic [1:0] op, input logic [31:0] d,
                           input logic [4:0] s, input logic [31:0] exp_d, input int exp_lat,
                           input string nm);
        bit got;
        int n;
        @(posedge clk); #1;
        drive(id, op, d, s);
        wait_acc(id, got);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got) timeout({nm, "_accept"});
        else begin
            wait_rsp(n, got);
            if (!got) timeout({nm, "_rsp"});
            else begin
                chk({nm, "_latency"}, n, exp_lat);
                chk({nm, "_data"}, rsp_data, exp_d);
                chk({nm, "_id"}, rsp_id, id);
            end
        end
    endtask

    initial begin : main
        bit got;
        int n;
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 2'b00; req0_data = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_data = '0; req1_shamt = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id", rsp_id, 1'b0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_req0_ready", req0_ready, 1'b0);
        chk("reset_req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Round robin from rr_ptr=0, then backpressure with a queued command.
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 32'h100, 5'd8);
        drive(1'b1, 2'b00, 32'h100, 5'd8);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk); #1;
            got = acc0 | acc1;
        end
        if (!got) timeout("rr_first_accept");
        chk("rr_first_is_req0", acc0, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(n, got);
        if (!got) timeout("rr_first_rsp");
        chk("rr_first_data", rsp_data, 32'h1);
        chk("rr_first_id", rsp_id, 1'b0);
        @(negedge clk); #1;
        chk("rr_second_accept_next_cycle", acc1, 1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        drive(1'b0, 2'b00, 32'hABCD_0000, 5'd16);
        wait_rsp(n, got);
        if (!got) timeout("bp_rsp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_data_stable", rsp_data, 32'h1);
            chk("bp_id_stable", rsp_id, 1'b1);
            chk("bp_req0_ready", req0_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_acc(1'b0, got);
        if (!got) timeout("bp_queued_accept");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_rsp(n, got);
        if (!got) timeout("bp_queued_rsp");
        chk("bp_queued_data", rsp_data, 32'h0000_ABCD);

        run_one(1'b0, 2'b00, 32'hF000_0000, 5'd4,  32'h0F00_0000, 2, "srl_4");
        run_one(1'b1, 2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 3, "sra_31");
        run_one(1'b1, 2'b01, 32'h8000_0000, 5'd0,  32'h8000_0000, 3, "sra_0");
        run_one(1'b0, 2'b10, 32'h0000_0001, 5'd31, 32'h8000_0000, 2, "sll_31");
        run_one(1'b0, 2'b00, 32'h8000_0000, 5'd31, 32'h0000_0001, 2, "srl_31");
        run_one(1'b1, 2'b11, 32'h1234_5678, 5'd8,  32'h0012_3456, 2, "rsvd_8");

        // Reset asserted during the MASK pass of an SRA.
        @(posedge clk); #1;
        drive(1'b1, 2'b01, 32'h8765_4321, 5'd4);
        wait_acc(1'b1, got);
        if (!got) timeout("rst_mid_accept");
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mid_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        run_one(1'b1, 2'b01, 32'h8765_4321, 5'd4, 32'hF876_5432, 3, "after_rst_sra");

        // Randomized traffic; valids hold until the model sees them accepted.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (req0_valid && acc0) req0_valid = 1'b0;
            if (req1_valid && acc1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 2) == 0)
                drive(1'b0, 2'($urandom_range(0, 3)), $urandom(), 5'($urandom_range(0, 31)));
            if (!req1_valid && $urandom_range(0, 2) == 0)
                drive(1'b1, 2'($urandom_range(0, 3)), $urandom() | 32'h8000_0000,
                      5'($urandom_range(0, 31)));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        if (req0_valid && acc0) req0_valid = 1'b0;
        if (req1_valid && acc1) req1_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (req0_valid && acc0) req0_valid = 1'b0;
            if (req1_valid && acc1) req1_valid = 1'b0;
        end
        chk("drain_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
